// File: rtl/seg7_scan_decoder.sv
// Receive-side decoder for a multiplexed 4-digit seven-segment bus: settles, decodes
// and reassembles 16-bit frames. Optional watchdog enabled by macro SEG7_WATCHDOG_EN.
`timescale 1ns/1ps
module seg7_scan_decoder #(
  parameter int unsigned SETTLE    = 4,
  parameter int unsigned TIMEOUT_W = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  digit_sel_in,
  output logic [15:0] value,
  output logic        value_valid,
  output logic [3:0]  digit_err,
  output logic        sel_err,
  output logic        link_lost
);

  typedef enum logic [0:0] {ACQUIRE, RUN} state_t;

  localparam logic [7:0] SETTLE_MAX = 8'(SETTLE);
  localparam logic [7:0] SETTLE_M1  = 8'(SETTLE - 1);

  logic [6:0]  seg_s1_q, seg_s2_q;
  logic [3:0]  sel_s1_q, sel_s2_q;
  logic [10:0] prev_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        captured_q, captured_d;
  state_t      state_q, state_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  err_sh_q, err_sh_d;
  logic [3:0]  seen_q, seen_d;
  logic [15:0] value_q, value_d;
  logic [3:0]  digit_err_q, digit_err_d;
  logic        value_valid_q, value_valid_d;
  logic        sel_err_q, sel_err_d;

  logic        same, strobe, cap;
  logic [1:0]  sel_idx;
  logic        sel_ok, sel_bad;
  logic [3:0]  nib;
  logic        seg_bad;
  logic        wd_expired;
  logic [15:0] shadow_n;
  logic [3:0]  err_n, seen_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      sel_s1_q <= '1;
      sel_s2_q <= '1;
      prev_q   <= {4'hF, 7'h00};
    end else begin
      seg_s1_q <= seg_in;
      seg_s2_q <= seg_s1_q;
      sel_s1_q <= digit_sel_in;
      sel_s2_q <= sel_s1_q;
      prev_q   <= {sel_s2_q, seg_s2_q};
    end
  end

  // One strobe per dwell: captured blocks re-firing until the bus changes.
  always_comb begin
    same       = ({sel_s2_q, seg_s2_q} == prev_q);
    strobe     = same && (cnt_q == SETTLE_M1) && !captured_q;
    cnt_d      = '0;
    captured_d = 1'b0;
    if (same) begin
      cnt_d      = (cnt_q == SETTLE_MAX) ? cnt_q : cnt_q + 8'd1;
      captured_d = captured_q | strobe;
    end
  end

  always_comb begin
    sel_idx = '0;
    sel_ok  = 1'b0;
    sel_bad = 1'b0;
    case (sel_s2_q)
      4'b1110: begin sel_idx = 2'd0; sel_ok = 1'b1; end
      4'b1101: begin sel_idx = 2'd1; sel_ok = 1'b1; end
      4'b1011: begin sel_idx = 2'd2; sel_ok = 1'b1; end
      4'b0111: begin sel_idx = 2'd3; sel_ok = 1'b1; end
      4'b1111: ;
      default: sel_bad = 1'b1;
    endcase
    cap = strobe && sel_ok;
  end

  always_comb begin
    nib     = 4'hE;
    seg_bad = 1'b0;
    case (seg_s2_q)
      7'b1111110: nib = 4'h0;
      7'b0110000: nib = 4'h1;
      7'b1101101: nib = 4'h2;
      7'b1111001: nib = 4'h3;
      7'b0110011: nib = 4'h4;
      7'b1011011: nib = 4'h5;
      7'b1011111: nib = 4'h6;
      7'b1110000: nib = 4'h7;
      7'b1111111: nib = 4'h8;
      7'b1111011: nib = 4'h9;
      7'b0000001: nib = 4'hF;
      default:    seg_bad = 1'b1;
    endcase
  end

`ifdef SEG7_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] wd_q, wd_d;

  always_comb begin
    wd_d = '0;
    if (state_q == RUN && !cap) wd_d = wd_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) wd_q <= '0;
    else     wd_q <= wd_d;
  end

  assign wd_expired = (wd_q == '1);
`else
  logic unused_timeout_w;
  assign unused_timeout_w = (TIMEOUT_W != 0);
  assign wd_expired       = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    err_sh_d      = err_sh_q;
    seen_d        = seen_q;
    value_d       = value_q;
    digit_err_d   = digit_err_q;
    value_valid_d = 1'b0;
    sel_err_d     = strobe && sel_bad;
    shadow_n      = shadow_q;
    err_n         = err_sh_q;
    seen_n        = seen_q;
    shadow_n[{sel_idx, 2'b00} +: 4] = nib;
    err_n[sel_idx]                  = seg_bad;
    seen_n[sel_idx]                 = 1'b1;
    case (state_q)
      ACQUIRE: begin
        if (cap && sel_idx == 2'd0) begin
          shadow_d[3:0] = nib;
          err_sh_d      = {3'b000, seg_bad};
          seen_d        = 4'b0001;
          state_d       = RUN;
        end
      end
      RUN: begin
        if (cap) begin
          shadow_d = shadow_n;
          if (seen_n == 4'b1111) begin
            value_d       = shadow_n;
            digit_err_d   = err_n;
            value_valid_d = 1'b1;
            seen_d        = '0;
            err_sh_d      = '0;
          end else begin
            seen_d   = seen_n;
            err_sh_d = err_n;
          end
        end else if (wd_expired) begin
          state_d  = ACQUIRE;
          seen_d   = '0;
          err_sh_d = '0;
        end
      end
      default: state_d = ACQUIRE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      captured_q    <= 1'b0;
      state_q       <= ACQUIRE;
      shadow_q      <= '0;
      err_sh_q      <= '0;
      seen_q        <= '0;
      value_q       <= '0;
      digit_err_q   <= '0;
      value_valid_q <= 1'b0;
      sel_err_q     <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      captured_q    <= captured_d;
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      err_sh_q      <= err_sh_d;
      seen_q        <= seen_d;
      value_q       <= value_d;
      digit_err_q   <= digit_err_d;
      value_valid_q <= value_valid_d;
      sel_err_q     <= sel_err_d;
    end
  end

  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign digit_err   = digit_err_q;
  assign sel_err     = sel_err_q;
  assign link_lost   = (state_q == ACQUIRE);

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Receive-side counterpart of the multiplexed 4-digit seven-segment driver. Samples the time-multiplexed segment and digit-select lines and decodes each digit's segment pattern back to a nibble. Reassembles complete 16-bit frames and reports them with a one-cycle valid strobe. Used in loopback self-test and to capture display traffic from external boards.

## Interface
- `SETTLE`, default 4: consecutive identical synchronized samples required before a digit is captured (legal range 2..255).
- `TIMEOUT_W`, default 20: watchdog counter width; link is declared lost when the counter reaches 2^TIMEOUT_W−1.
- `clk` in, 1: single clock; all logic on its rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `seg_in` in, 7: segments a..g, bit6=a, active-high.
- `digit_sel_in` in, 4: digit enables, active-low, one-cold; bit i selects digit i.
- `value` out, 16: last complete frame; digit i at `[4i+3:4i]`. Reset 16'h0000.
- `value_valid` out, 1: one-cycle pulse when `value` updates. Reset 0.
- `digit_err` out, 4: per-digit unrecognized-pattern flags for the frame in `value`. Reset 4'h0.
- `sel_err` out, 1: one-cycle pulse on an illegal select pattern. Reset 0.
- `link_lost` out, 1: high while not frame-aligned. Reset 1.

## Operation
- **Input synchronizer:** both buses pass through a 2-flop synchronizer; all downstream logic uses the synchronized copies.
- **Settle counter:** compares synchronized {sel, seg} with the previous cycle's value.
  - Equal → count increments, saturating at SETTLE.
  - Differ → count clears to 0 and the `captured` flag clears.
  - Capture strobe fires when count == SETTLE−1 and `captured`=0; strobe sets `captured`. Result: exactly one capture per dwell.
- **Select decode at strobe:**
  - Exactly one zero → index 0..3; strobe is valid.
  - 4'b1111 (blanking) → no capture, no error.
  - Anything else → `sel_err` pulse, no capture.
- **Segment decode:**
  - 0:1111110, 1:0110000, 2:1101101, 3:1111001, 4:0110011, 5:1011011, 6:1011111, 7:1110000, 8:1111111, 9:1111011.
  - 0000001 (dash) → 4'hF, no error.
  - Any other pattern → 4'hE and the error bit is set for that digit.
- **FSM states:**
  - ACQUIRE (reset state; `link_lost`=1): valid captures with index ≠0 are discarded. A capture with index 0 stores digit 0, sets seen[0] and moves to RUN.
  - RUN (`link_lost`=0): each valid capture writes shadow nibble, error bit and seen[index]. Recapturing an already-seen digit overwrites it, no error.
  - When seen becomes 4'b1111 (including the current capture): `value`←shadow, `digit_err`←error shadow, `value_valid`=1 for one cycle, seen and error shadow clear.
- **Watchdog:** increments every cycle in RUN and clears on every valid capture. On reaching terminal count:
  - go to ACQUIRE, clear seen;
  - `value` and `digit_err` hold.
- **Reset mid-frame:** all state returns to reset values at the next edge. A partial frame is discarded and never reported.

## Timing
- Pin change to capture strobe: 2 (sync) + SETTLE cycles. `value`/`value_valid` register one cycle later, so pin-to-valid latency for the final digit is SETTLE+3 cycles.
- `sel_err` asserts in the cycle after the strobe for the illegal pattern.
- `link_lost` falls in the cycle after the index-0 capture strobe. It rises in the cycle after the watchdog hits terminal count.
- Dwells shorter than SETTLE synchronized cycles are ignored silently.
- A seg change with sel held (glitch) restarts settling. Capture then occurs again on the new stable pattern and overwrites the digit.

## Configuration
- Macro `SEG7_WATCHDOG_EN`.
  - **Defined:** watchdog as described above.
  - **Undefined:** no counter is instantiated and `TIMEOUT_W` is unused. Once in RUN the block stays in RUN until `rst`, so `link_lost` falls after the first index-0 capture and stays 0.

## Test plan
- Drive the 0x1234 frame, digits 0..3, each held 20 cycles with SETTLE=4 (sel 1110/seg 0110011, 1101/1111001, 1011/1101101, 0111/0110000) → `value`=16'h1234, `value_valid` one pulse 7 cycles after digit 3 appears, `digit_err`=0.
- Start the stream at digit 2, then digits 3,0,1,2,3 → first two captures are ignored; the frame reported after digit 3 of the second pass; `link_lost` falls after the digit-0 capture.
- Send digit 1 as 0000001 and digit 3 as 1000000 → `value`=16'hE3F4 for a 0x?3?4 base frame, `digit_err`=4'b1000.
- Drive sel 1100 for 10 cycles → single `sel_err` pulse, no seen update; sel 1111 for 10 cycles → no pulse.
- Stop toggling after a valid frame (watchdog enabled, TIMEOUT_W=8) → `link_lost` rises 255 cycles after the last capture and `value` holds.
- Assert `rst` after digits 0,1 captured, then send digits 2,3,0,1,2,3 → no valid from the partial frame; the first `value_valid` follows the second digit 3.
